// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// Stopwatch control: button edge detection, IDLE/RUN/LAP/PAUSE state machine,
// BCD mm:ss.cc timekeeping, lap capture and the registered display mux.
module stopwatch_ctrl #(
  parameter int TICK_MAX = 99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] TICK_HI = 4'(TICK_MAX / 10);
  localparam logic [3:0] TICK_LO = 4'(TICK_MAX % 10);

  // Returns {wrap, next_time}; wrap is set when 59:59.<TICK_MAX> rolls over.
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [3:0] m1, m0, s1, s0, c1, c0;
    logic       cy_s, cy_m, wrap;
    {m1, m0, s1, s0, c1, c0} = t;
    cy_s = 1'b0;
    cy_m = 1'b0;
    wrap = 1'b0;
    if (c1 == TICK_HI && c0 == TICK_LO) begin
      c1 = 4'd0; c0 = 4'd0; cy_s = 1'b1;
    end else if (c0 == 4'd9) begin
      c0 = 4'd0; c1 = c1 + 4'd1;
    end else begin
      c0 = c0 + 4'd1;
    end
    if (cy_s) begin
      if (s1 == 4'd5 && s0 == 4'd9) begin
        s1 = 4'd0; s0 = 4'd0; cy_m = 1'b1;
      end else if (s0 == 4'd9) begin
        s0 = 4'd0; s1 = s1 + 4'd1;
      end else begin
        s0 = s0 + 4'd1;
      end
    end else begin
      cy_m = 1'b0;
    end
    if (cy_m) begin
      if (m1 == 4'd5 && m0 == 4'd9) begin
        m1 = 4'd0; m0 = 4'd0; wrap = 1'b1;
      end else if (m0 == 4'd9) begin
        m0 = 4'd0; m1 = m1 + 4'd1;
      end else begin
        m0 = m0 + 4'd1;
      end
    end else begin
      wrap = 1'b0;
    end
    return {wrap, m1, m0, s1, s0, c1, c0};
  endfunction

  state_t      state_r;
  logic        start_q_r, lap_q_r, clear_q_r;
  logic [23:0] count_r, lap_r;
  logic        start_raw_s, clear_p_s, start_p_s, lap_p_s;
  logic        count_adv_s, wrap_s;
  logic [23:0] count_inc_s, live_n_s;

  // Press decode with clear > start > lap priority, plus the next live count.
  always_comb begin
    start_raw_s              = btn_start & ~start_q_r;
    clear_p_s                = btn_clear & ~clear_q_r;
    start_p_s                = start_raw_s & ~clear_p_s;
    lap_p_s                  = btn_lap & ~lap_q_r & ~clear_p_s & ~start_raw_s;
    count_adv_s              = tick & ((state_r == RUN) | (state_r == LAP));
    {wrap_s, count_inc_s}    = bcd_inc(count_r);
    live_n_s                 = count_adv_s ? count_inc_s : count_r;
  end

  // One-cycle copies of the button levels for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q_r <= 1'b0;
      lap_q_r   <= 1'b0;
      clear_q_r <= 1'b0;
    end else begin
      start_q_r <= btn_start;
      lap_q_r   <= btn_lap;
      clear_q_r <= btn_clear;
    end
  end

  // State machine, time/lap registers and registered outputs; branch
  // assignments below override the live-count defaults where needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= 24'h000000;
      lap_r      <= 24'h000000;
      digits     <= 24'h000000;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      count_r    <= live_n_s;
      digits     <= live_n_s;
      overflow   <= count_adv_s & wrap_s;
      lap_active <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_p_s) begin
            state_r <= RUN;
            running <= 1'b1;
          end else begin
            state_r <= IDLE;
            running <= 1'b0;
          end
        end
        RUN: begin
          if (start_p_s) begin
            state_r <= PAUSE;
            running <= 1'b0;
          end else if (lap_p_s) begin
            state_r    <= LAP;
            running    <= 1'b1;
            lap_active <= 1'b1;
            lap_r      <= count_r;
            digits     <= count_r;
          end else begin
            state_r <= RUN;
            running <= 1'b1;
          end
        end
        LAP: begin
          if (start_p_s) begin
            state_r <= PAUSE;
            running <= 1'b0;
          end else if (lap_p_s) begin
            state_r <= RUN;
            running <= 1'b1;
          end else begin
            state_r    <= LAP;
            running    <= 1'b1;
            lap_active <= 1'b1;
            digits     <= lap_r;
          end
        end
        PAUSE: begin
          if (clear_p_s) begin
            state_r <= IDLE;
            running <= 1'b0;
            count_r <= 24'h000000;
            lap_r   <= 24'h000000;
            digits  <= 24'h000000;
          end else if (start_p_s) begin
            state_r <= RUN;
            running <= 1'b1;
          end else begin
            state_r <= PAUSE;
            running <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timekeeping block for the stopwatch. Takes the three debounced button outputs (start/stop, lap, clear) and a 100 Hz tick enable, runs the IDLE/RUN/LAP/PAUSE state machine, and maintains the BCD mm:ss.cc time count. It also holds the lap-capture register and drives the six BCD digits to the display driver. It sits between the per-button debounce instances and the 7-segment multiplexer.

## Interface
- TICK_MAX, default 99: terminal value of the centisecond digit pair; the count wraps from this value to 00 and carries into seconds.
- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- tick  in  1  one-cycle enable pulse at the centisecond rate, synchronous to clk.
- btn_start  in  1  debounced start/stop level, synchronous to clk; may stay high for many cycles.
- btn_lap  in  1  debounced lap level, same properties as btn_start.
- btn_clear  in  1  debounced clear level, same properties as btn_start.
- digits  out  24  BCD {m1,m0,s1,s0,c1,c0}, where m1 is the most significant digit.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP; digits show the frozen lap value while high.
- overflow  out  1  one-cycle pulse when the count wraps from 59:59.99 to 00:00.00.

## Operation
- Button inputs are levels, so the block edge-detects them internally. Each input has a 1-cycle registered copy, and press = input & ~copy. A level held high counts as exactly one press.
- Each cycle, only the highest-priority press acts. Priority is clear > start > lap; lower-priority presses in the same cycle are discarded.
- State machine, reset state IDLE:
  - IDLE: start -> RUN. Lap and clear are ignored. The count is held at zero.
  - RUN: start -> PAUSE. Lap -> LAP, and the current count is copied into the lap register on the same edge. Clear is ignored.
  - LAP: lap -> RUN, and digits return to the live count. Start -> PAUSE, and digits return to the live count. Clear is ignored. Counting continues throughout LAP.
  - PAUSE: start -> RUN. Clear -> IDLE, and the count and lap register are zeroed on the same edge. Lap is ignored.
- Counting:
  - Advances by one centisecond on each edge where tick=1 and the current registered state is RUN or LAP.
  - The state being entered on that edge does not decide whether the count advances.
  - Each digit is stored as BCD.
  - Carry chain: c0 9 -> 0 carries into c1. The c1:c0 pair wraps at TICK_MAX (99) and carries into seconds. Seconds wrap at 59 and carry into minutes. Minutes wrap at 59 and carry out to overflow.
  - 59:59.99 plus one tick gives 00:00.00 with overflow=1 for that one cycle. State does not change.
- digits = lap_active ? lap register : live count. The mux is driven only from registers, with no combinational path from the button inputs.
- Reset mid-operation: all registers clear asynchronously, including the edge-detect copies. A button still held high after reset releases is seen as a new press once its copy has sampled 0. Because the copies reset to 0, that press registers on the first edge after release.

## Timing
- Values while reset is asserted and on the first edge after release, before any press or tick: state IDLE, digits 0x000000, running 0, lap_active 0, overflow 0, lap register 0, edge-detect copies 0.
- Press latency: the state changes on the first clk edge at which the input is sampled 1 after having been 0. running and lap_active are valid after that edge.
- Count latency: digits reflect an increment on the same edge at which tick=1 is sampled.
- Lap capture: the value captured is the count held in the register just before the capturing edge. A tick on the capturing edge still advances the live count but does not change the captured value.
- overflow is registered and high for exactly the cycle after the wrap edge.
- Press and tick on the same edge: counting is decided by the old state. Example: RUN, start+tick together -> the count advances once, then PAUSE.

## Test plan
- Reset, start pulse, 150 ticks -> digits=0x000150, running=1. Start again, then 10 ticks -> digits stay 0x000150, running=0.
- Hold btn_start high for 1000 cycles with ticks → exactly one transition to RUN; the state does not toggle back.
- RUN at 0x000042, lap press → lap_active=1 and digits freeze at 0x000042. Then 58 ticks → digits still 0x000042. Lap again → digits=0x000100.
- Preload by ticking up to 0x595999, one more tick → digits=0x000000, overflow high for one cycle, running stays 1.
- PAUSE at 0x001234, clear+start+lap on the same edge → state IDLE, digits=0x000000, running=0. Clear pressed in RUN → ignored, digits keep counting.
- Assert reset while in LAP with the count non-zero, held 3 cycles, btn_start held high throughout → all outputs 0 while reset is asserted. After release → enters RUN on the first edge after release.
